// File: rtl/spectral_shift_ctrl.sv
// Pitch-shift resampler: walks the output bins, linearly interpolates two neighbouring source
// bins at a Q4.12 position, writes the output RAM and arbitrates its address port with the IFFT.
module spectral_shift_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned RATIO_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RATIO_W-1:0]       shift_ratio,
    output logic [ADDR_W-1:0]        src_raddr,
    input  logic signed [DATA_W-1:0] src_real,
    input  logic signed [DATA_W-1:0] src_imag,
    input  logic [ADDR_W-1:0]        ifft_raddr,
    output logic [ADDR_W-1:0]        dst_addr,
    output logic [ADDR_W-1:0]        dst_waddr,
    output logic [2*DATA_W-1:0]      dst_wdata,
    output logic                     dst_we,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned FRAC_W = 12;
    localparam int unsigned P_W    = ADDR_W + RATIO_W;
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;
    localparam logic [ADDR_W-1:0] LAST_BIN = {ADDR_W{1'b1}};

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CALC   = 3'd1;
    localparam logic [2:0] RD_A   = 3'd2;
    localparam logic [2:0] RD_B   = 3'd3;
    localparam logic [2:0] LAT_B  = 3'd4;
    localparam logic [2:0] INTERP = 3'd5;
    localparam logic [2:0] WRITE  = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    // a + floor((b - a) * frac / 4096); a convex combination, so truncation is exact.
    function automatic logic signed [DATA_W-1:0] lerp(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b,
                                                      input logic [FRAC_W-1:0]        frac);
        logic signed [DATA_W:0]   diff;
        logic signed [PROD_W-1:0] prod;
        diff = {b[DATA_W-1], b} - {a[DATA_W-1], a};
        prod = PROD_W'(diff) * $signed(PROD_W'({1'b0, frac}));
        return a + DATA_W'(prod >>> FRAC_W);
    endfunction

    logic [2:0]               state_q, state_d;
    logic [RATIO_W-1:0]       ratio_q, ratio_d;
    logic [ADDR_W-1:0]        k_q, k_d;
    logic [ADDR_W-1:0]        src_raddr_q, src_raddr_d;
    logic [FRAC_W-1:0]        frac_q, frac_d;
    logic signed [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d;
    logic signed [DATA_W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;
    logic [2*DATA_W-1:0]      wdata_q, wdata_d;

    logic [P_W-1:0]           pos;
    logic                     zero_bin;

    assign pos      = P_W'(k_q) * P_W'(ratio_q);
    assign zero_bin = |pos[P_W-1:FRAC_W+ADDR_W];

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        k_d         = k_q;
        src_raddr_d = src_raddr_q;
        frac_d      = frac_q;
        a_re_d      = a_re_q;
        a_im_d      = a_im_q;
        b_re_d      = b_re_q;
        b_im_d      = b_im_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ratio_d = shift_ratio;
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (zero_bin) begin
                    wdata_d = '0;
                    state_d = WRITE;
                end else begin
                    src_raddr_d = pos[FRAC_W+ADDR_W-1:FRAC_W];
                    frac_d      = pos[FRAC_W-1:0];
                    state_d     = RD_A;
                end
            end
            RD_A: begin
                // Clamp so the last bin reads itself twice rather than past the end.
                src_raddr_d = (src_raddr_q == LAST_BIN) ? LAST_BIN : src_raddr_q + ADDR_W'(1);
                state_d     = RD_B;
            end
            RD_B: begin
                a_re_d  = src_real;
                a_im_d  = src_imag;
                state_d = LAT_B;
            end
            LAT_B: begin
                b_re_d  = src_real;
                b_im_d  = src_imag;
                state_d = INTERP;
            end
            INTERP: begin
                wdata_d = {lerp(a_re_q, b_re_q, frac_q), lerp(a_im_q, b_im_q, frac_q)};
                state_d = WRITE;
            end
            WRITE: begin
                if (k_q == LAST_BIN) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    state_d = CALC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ratio_q     <= '0;
            k_q         <= '0;
            src_raddr_q <= '0;
            frac_q      <= '0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ratio_q     <= ratio_d;
            k_q         <= k_d;
            src_raddr_q <= src_raddr_d;
            frac_q      <= frac_d;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign dst_we    = (state_q == WRITE);
    assign dst_waddr = k_q;
    assign dst_wdata = wdata_q;
    assign src_raddr = src_raddr_q;
    assign dst_addr  = busy ? k_q : ifft_raddr;

endmodule

// File: tb/tb_spectral_shift_ctrl.sv
// Bench for spectral_shift_ctrl: vector table, directed corner sequences and random passes
// checked against an arithmetic resampling model.
module tb_spectral_shift_ctrl;

    localparam int AW = 9;
    localparam int DW = 18;
    localparam int RW = 16;
    localparam int NB = 512;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [RW-1:0]        shift_ratio = '0;
    logic [AW-1:0]        src_raddr;
    logic signed [DW-1:0] src_real = '0;
    logic signed [DW-1:0] src_imag = '0;
    logic [AW-1:0]        ifft_raddr = '0;
    logic [AW-1:0]        dst_addr;
    logic [AW-1:0]        dst_waddr;
    logic [2*DW-1:0]      dst_wdata;
    logic                 dst_we;
    logic                 busy;
    logic                 done;

    spectral_shift_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RATIO_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shift_ratio(shift_ratio),
        .src_raddr  (src_raddr),
        .src_real   (src_real),
        .src_imag   (src_imag),
        .ifft_raddr (ifft_raddr),
        .dst_addr   (dst_addr),
        .dst_waddr  (dst_waddr),
        .dst_wdata  (dst_wdata),
        .dst_we     (dst_we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source spectrum RAM with one-cycle read latency.
    logic signed [DW-1:0] src_re_mem[NB];
    logic signed [DW-1:0] src_im_mem[NB];
    always @(posedge clk) begin
        src_real <= src_re_mem[src_raddr];
        src_imag <= src_im_mem[src_raddr];
    end

    logic [2*DW-1:0] dst_mem[NB];
    int exp_re[NB];
    int exp_im[NB];
    int exp_lat;
    int n_pass = 0, n_total = 0;
    int we_cnt = 0, done_cnt = 0, t0 = 0, done_at = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Output RAM observer: writes must walk bins in order and own the RAM port.
    always @(negedge clk) begin
        if (dst_we) begin
            chk("waddr_seq", dst_waddr, we_cnt);
            chk("dst_addr_busy", dst_addr, we_cnt);
            dst_mem[dst_waddr] = dst_wdata;
            we_cnt++;
        end
        if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
            chk("dst_addr_at_done", dst_addr, ifft_raddr);
        end
    end

    function automatic int floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q--;
        return int'(q);
    endfunction

    task automatic model(input int r);
        exp_lat = 0;
        for (int k = 0; k < NB; k++) begin
            longint p;
            int idx, frac, nxt, a, b;
            p    = longint'(k) * r;
            idx  = int'(p / 4096);
            frac = int'(p % 4096);
            if (idx > NB - 1) begin
                exp_re[k] = 0;
                exp_im[k] = 0;
                exp_lat += 2;
            end else begin
                nxt = (idx == NB - 1) ? idx : idx + 1;
                a = src_re_mem[idx];
                b = src_re_mem[nxt];
                exp_re[k] = a + floor_div(longint'(b - a) * frac, 4096);
                a = src_im_mem[idx];
                b = src_im_mem[nxt];
                exp_im[k] = a + floor_div(longint'(b - a) * frac, 4096);
                exp_lat += 6;
            end
        end
    endtask

    task automatic load_src(input int kind);
        for (int i = 0; i < NB; i++) begin
            case (kind)
                0: begin src_re_mem[i] = DW'(100 * i); src_im_mem[i] = DW'(-i); end
                1: begin src_re_mem[i] = DW'(i);       src_im_mem[i] = DW'(-i); end
                default: begin src_re_mem[i] = DW'($urandom); src_im_mem[i] = DW'($urandom); end
            endcase
        end
    endtask

    task automatic run_pass(input int r, input int extra_at);
        bit got;
        @(negedge clk);
        model(r);
        for (int i = 0; i < NB; i++) dst_mem[i] = '1;
        we_cnt      = 0;
        done_cnt    = 0;
        ifft_raddr  = AW'(341);
        start       = 1'b1;
        shift_ratio = RW'(r);
        t0          = cyc;
        @(negedge clk);
        start       = 1'b0;
        shift_ratio = RW'($urandom);
        got = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            start = (n == extra_at);
            if (done) begin
                done_at = cyc;
                got     = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            start = 1'b0;
            chk("done_timeout", 0, 1);
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("start_in_done_ignored", busy, 0);
            chk("latency", done_at - t0, exp_lat + 1);
        end
        @(negedge clk);
        chk("we_count", we_cnt, NB);
        chk("done_count", done_cnt, 1);
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("bin%0d_re", k), $signed(dst_mem[k][2*DW-1:DW]), exp_re[k]);
            chk($sformatf("bin%0d_im", k), $signed(dst_mem[k][DW-1:0]), exp_im[k]);
        end
    endtask

    typedef struct {
        int r;
        int k;
        int re;
        int im;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  last_r;
        int  saved;
        bit  got;
        // Source pattern: real = 100k, imag = -k.
        tbl[0] = '{4096, 5, 500, -5};
        tbl[1] = '{4096, 511, 51100, -511};
        tbl[2] = '{2048, 3, 150, -2};
        tbl[3] = '{2048, 511, 25550, -256};
        tbl[4] = '{8192, 255, 51000, -510};
        tbl[5] = '{8192, 256, 0, 0};
        tbl[6] = '{8192, 0, 0, 0};

        ifft_raddr = AW'(77);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", dst_we, 0);
        chk("rst_src_raddr", src_raddr, 0);
        chk("rst_dst_waddr", dst_waddr, 0);
        chk("rst_dst_wdata", dst_wdata, 0);
        chk("rst_dst_addr", dst_addr, 77);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NB; i++) begin
            ifft_raddr = AW'(i);
            #1;
            chk("idle_dst_addr", dst_addr, i);
        end

        last_r = -1;
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].r != last_r) begin
                load_src(0);
                run_pass(tbl[i].r, -1);
                last_r = tbl[i].r;
            end
            chk($sformatf("tbl%0d_re", i), $signed(dst_mem[tbl[i].k][2*DW-1:DW]), tbl[i].re);
            chk($sformatf("tbl%0d_im", i), $signed(dst_mem[tbl[i].k][DW-1:0]), tbl[i].im);
        end

        // Identity ratio.
        load_src(1);
        run_pass(4096, -1);
        chk("identity_latency", done_at - t0, 3073);
        for (int k = 0; k < NB; k += 37) begin
            chk("identity_re", $signed(dst_mem[k][2*DW-1:DW]), k);
            chk("identity_im", $signed(dst_mem[k][DW-1:0]), -k);
        end

        // Octave up: top half are zero bins.
        run_pass(8192, -1);
        chk("octave_latency", done_at - t0, 2049);
        chk("octave_bin100", $signed(dst_mem[100][2*DW-1:DW]), 200);
        chk("octave_bin255", $signed(dst_mem[255][2*DW-1:DW]), 510);
        chk("octave_bin400", dst_mem[400], 0);

        // Arithmetic shift must floor toward -inf.
        load_src(0);
        src_re_mem[1] = -DW'(1);
        run_pass(2048, -1);
        chk("floor_bin1", $signed(dst_mem[1][2*DW-1:DW]), -1);

        // Second start while busy.
        load_src(2);
        run_pass(4096, 100);

        // R = 0: every bin is src[0].
        load_src(2);
        run_pass(0, -1);
        chk("r0_bin300_re", $signed(dst_mem[300][2*DW-1:DW]), src_re_mem[0]);
        chk("r0_bin511_im", $signed(dst_mem[511][DW-1:0]), src_im_mem[0]);

        load_src(2);
        run_pass(int'($urandom_range(1, 16383)), -1);
        load_src(2);
        run_pass(int'($urandom_range(16384, 65535)), -1);

        // Reset in the middle of a pass, while a write is in flight.
        load_src(1);
        @(negedge clk);
        we_cnt      = 0;
        start       = 1'b1;
        shift_ratio = RW'(4096);
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (dst_we && dst_waddr == AW'(200)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_bin200", got, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", dst_we, 0);
        chk("midrst_done", done, 0);
        chk("midrst_waddr", dst_waddr, 0);
        saved = we_cnt;
        chk("writes_before_reset", saved, 201);
        repeat (5) @(negedge clk);
        chk("no_write_in_reset", we_cnt, saved);
        rst_n = 1'b1;
        run_pass(4096, -1);
        chk("post_reset_latency", done_at - t0, 3073);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
